// File: rtl/wb_trace_pkg.sv
// =============================================================================
// Module      : wb_trace_pkg
// Description : Shared types and widths for the writeback trace buffer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package wb_trace_pkg;

    localparam int SEQ_W      = 16;
    localparam int TRACE_XLEN = 32;
    localparam int RD_W       = 5;

    typedef struct packed {
        logic [SEQ_W-1:0]      seq;
        logic [TRACE_XLEN-1:0] pc;
        logic [RD_W-1:0]       rd;
        logic [TRACE_XLEN-1:0] data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } trace_state_e;

    function automatic int entry_width(input int xlen);
        return SEQ_W + 2 * xlen + RD_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_trace_fifo.sv
// =============================================================================
// Module      : wb_trace_fifo
// Description : Circular entry store with occupancy count and show-ahead head.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 85
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;
    logic w_ovw;
    logic w_write;
    logic w_read;

    assign full    = (r_count == c_CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;
    // Overwrite replaces the oldest entry: both pointers move, count holds.
    assign w_ovw   = overwrite & full;
    assign w_write = w_push | w_ovw;
    assign w_read  = w_pop | w_ovw;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_mem[i] <= '0;
                end else if (w_write && (r_wr_ptr == c_PTR_W'(i))) begin
                    r_mem[i] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_read)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - c_CNT_W'(1);
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/wb_trace_buffer.sv
// =============================================================================
// Module      : wb_trace_buffer
// Description : Captures pipeline writebacks and drains them oldest-first on
//               a dump request. Define WB_TRACE_OVERWRITE_EN to overwrite the
//               oldest entry when full instead of dropping the new event.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_e,
    input  logic [4:0]             wb_a,
    input  logic [XLEN-1:0]        wb_d,
    input  logic [XLEN-1:0]        pc_in,
    input  logic                   dump,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_seq,
    output logic [XLEN-1:0]        out_pc,
    output logic [4:0]             out_rd,
    output logic [XLEN-1:0]        out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   drain_done
);

    localparam int c_ENTRY_W = entry_width(XLEN);

    trace_state_e         r_state;
    trace_state_e         w_next_state;
    logic                 r_dump_q;
    logic [SEQ_W-1:0]     r_seq;
    logic                 r_overflow;

    logic                 w_event;
    logic                 w_dump_rise;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_overwrite;
    logic                 w_lost;
    logic                 w_full;
    logic                 w_empty;
    logic [c_ENTRY_W-1:0] w_wdata;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_event     = wb_e && (wb_a != 5'd0);
    assign w_dump_rise = dump && !r_dump_q;
    assign w_wdata     = {r_seq, pc_in, wb_a, wb_d};

    wb_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .overwrite (w_overwrite),
        .wdata     (w_wdata),
        .rdata     (w_head),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_overwrite  = 1'b0;
        w_pop        = 1'b0;
        w_lost       = 1'b0;
        out_valid    = 1'b0;
        drain_done   = 1'b0;
        case (r_state)
            CAPTURE: begin
                // An event coinciding with the dump edge is still stored.
                if (w_event) begin
                    if (!w_full) begin
                        w_push = 1'b1;
                    end else begin
`ifdef WB_TRACE_OVERWRITE_EN
                        w_overwrite = 1'b1;
`endif
                        w_lost = 1'b1;
                    end
                end
                if (w_dump_rise) w_next_state = DRAIN;
            end
            DRAIN: begin
                out_valid = !w_empty;
                w_pop     = out_valid && out_ready;
                if (w_empty) w_next_state = DONE;
            end
            DONE: begin
                drain_done = 1'b1;
                if (!dump) w_next_state = CAPTURE;
            end
            default: w_next_state = CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= CAPTURE;
            r_dump_q   <= 1'b0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_dump_q <= dump;
            if (w_push || w_overwrite) r_seq <= r_seq + SEQ_W'(1);
            if (w_lost)                                r_overflow <= 1'b1;
            else if ((r_state == DONE) && !dump)       r_overflow <= 1'b0;
        end
    end

    assign {out_seq, out_pc, out_rd, out_data} = w_head;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
// =============================================================================
// Module      : tb_wb_trace_buffer
// Description : Scoreboard bench for wb_trace_buffer (DEPTH=16, XLEN=32).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_wb_trace_buffer;
    import wb_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int XLEN  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_e = 1'b0;
    logic [4:0]  wb_a = '0;
    logic [31:0] wb_d = '0;
    logic [31:0] pc_in = '0;
    logic        dump = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_seq;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic        drain_done;

    int n_vec  = 0;
    int n_err  = 0;
    int n_pops = 0;

    trace_entry_t exp_q[$];
    logic [15:0]  exp_seq = '0;
    logic         exp_ovf = 1'b0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
        .pc_in(pc_in), .dump(dump), .out_valid(out_valid), .out_ready(out_ready),
        .out_seq(out_seq), .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data),
        .count(count), .overflow(overflow), .drain_done(drain_done)
    );

    // Monitor: every presented beat must match the scoreboard head.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat: got seq=%0h data=%0h, required no beat", out_seq, out_data);
            end else begin
                if ({out_seq, out_pc, out_rd, out_data} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL beat: got seq=%0h pc=%0h rd=%0d data=%0h, required seq=%0h pc=%0h rd=%0d data=%0h",
                             out_seq, out_pc, out_rd, out_data,
                             exp_q[0].seq, exp_q[0].pc, exp_q[0].rd, exp_q[0].data);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; dump = 1'b0; wb_e = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        tick(); tick();
        reset = 1'b1;
        exp_seq = '0;
        exp_ovf = 1'b0;
    endtask

    task automatic model_store(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
        if (rd != 5'd0) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back('{seq: exp_seq, pc: pc, rd: rd, data: data});
                exp_seq++;
            end else begin
`ifdef WB_TRACE_OVERWRITE_EN
                void'(exp_q.pop_front());
                exp_q.push_back('{seq: exp_seq, pc: pc, rd: rd, data: data});
                exp_seq++;
`endif
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc, input bit store);
        wb_e = 1'b1; wb_a = rd; wb_d = data; pc_in = pc;
        if (store) model_store(rd, data, pc);
        tick();
        wb_e = 1'b0;
    endtask

    task automatic finish_drain(input bit toggle);
        for (int i = 0; i < 200 && !drain_done; i++) begin
            if (toggle) out_ready = ~out_ready;
            tick();
        end
        check("drain_done", drain_done, 1'b1);
        check("drain_count", count, 0);
        check("drain_valid", out_valid, 1'b0);
        check("beats_missing", exp_q.size(), 0);
        dump = 1'b0; out_ready = 1'b0;
        tick();
        check("done_exit", drain_done, 1'b0);
        check("ovf_clear", overflow, 1'b0);
        exp_ovf = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        dump = 1'b1; out_ready = 1'b1;
        tick();
        check("valid_latency", out_valid, (exp_q.size() != 0));
        check("drain_first", drain_done, 1'b0);
        finish_drain(toggle);
    endtask

    initial begin
        int base;
        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_done", drain_done, 1'b0);
        check("rst_fields", {out_seq, out_rd, out_pc}, 0);
        check("rst_data", out_data, 0);

        // Basic capture and ordered drain.
        wb(5'd1, 32'hDEADBEEF, 32'h0, 1);
        wb(5'd2, 32'h12345678, 32'h4, 1);
        wb(5'd7, 32'h00000004, 32'h8, 1);
        check("count3", count, 3);
        drain(1'b0);

        // Empty drain: one DRAIN cycle then DONE.
        drain(1'b0);

        // x0 writes are ignored and consume no sequence number.
        do_reset();
        wb(5'd0, 32'h55, 32'h10, 1);
        check("x0_count", count, 0);
        wb(5'd3, 32'hA5A5A5A5, 32'h14, 1);
        check("x3_count", count, 1);
        check("x3_seq", out_seq, 16'h0);
        drain(1'b0);

        // Overfill by three.
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++)
            wb(5'((i % 31) + 1), 32'(i), 32'(i * 4), 1);
        check("full_count", count, DEPTH);
        check("full_ovf", overflow, 1'b1);
        drain(1'b0);

        // Backpressure: ready toggles every cycle.
        do_reset();
        for (int i = 0; i < 6; i++)
            wb(5'(i + 10), 32'hC000_0000 + 32'(i), 32'h100 + 32'(i * 4), 1);
        drain(1'b1);

        // Dump edge coincides with a writeback; writes during DRAIN are ignored.
        do_reset();
        wb(5'd4, 32'h44, 32'h200, 1);
        wb_e = 1'b1; wb_a = 5'd5; wb_d = 32'hFEDCBA98; pc_in = 32'h204; dump = 1'b1;
        model_store(5'd5, 32'hFEDCBA98, 32'h204);
        tick();
        wb_e = 1'b0;
        check("same_cycle_count", count, 2);
        check("same_cycle_valid", out_valid, 1'b1);
        wb(5'd9, 32'h99, 32'h208, 0);
        check("drain_nocapture", count, 2);
        out_ready = 1'b1;
        finish_drain(1'b0);

        // Reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < 5; i++)
            wb(5'(i + 20), 32'h5000 + 32'(i), 32'h300 + 32'(i * 4), 1);
        base = n_pops;
        dump = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 50 && (n_pops - base) < 2; i++) tick();
        check("mid_pops", n_pops - base, 2);
        reset = 1'b0; dump = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        exp_seq = '0; exp_ovf = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_done", drain_done, 1'b0);
        wb(5'd6, 32'h66, 32'h400, 1);
        check("post_rst_capture", count, 1);
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Commit-trace capture block sitting directly downstream of `riscv_pipeline`. It samples the pipeline's register-file writeback port (`wb_e`/`wb_a`/`wb_d`) together with `pc_out` into a circular buffer. When `dump` is raised, it drains the captured entries oldest-first over a valid/ready stream. Benches and the debug path use it to check architectural results without peeking into the register file.

## Interface
Parameters:
- `DEPTH`, 16 — entry count; power of two, ≥ 2.
- `XLEN`, 32 — data and PC width.

Ports:
- `clk` in 1 — single clock; all logic is on the rising edge.
- `reset` in 1 — synchronous, active-low; `reset==0` at a clock edge resets the block.
- `wb_e` in 1 — writeback enable from the pipeline.
- `wb_a` in 5 — writeback destination register.
- `wb_d` in XLEN — writeback data.
- `pc_in` in XLEN — pipeline `pc_out`, sampled alongside the writeback.
- `dump` in 1 — level request to drain the buffer.
- `out_valid` out 1 — head entry is presented.
- `out_ready` in 1 — consumer accepts the head entry.
- `out_seq` out 16 — sequence number of the head entry.
- `out_pc` out XLEN — PC of the head entry.
- `out_rd` out 5 — destination register of the head entry.
- `out_data` out XLEN — data of the head entry.
- `count` out $clog2(DEPTH)+1 — current occupancy.
- `overflow` out 1 — sticky flag: an event was lost or overwritten.
- `drain_done` out 1 — drain finished.

## Operation
- FSM states: CAPTURE (reset state), DRAIN, DONE.
- Capture happens in CAPTURE only. An event is accepted when `wb_e==1 && wb_a!=0`. Writes to x0 are ignored.
- An accepted event writes {seq, pc_in, wb_a, wb_d} at the write pointer, increments the write pointer and `count`, and increments `seq_cnt`.
  - `seq_cnt` is 16 bits and wraps 0xFFFF→0x0000.
  - `seq_cnt` increments only on stored events; dropped events do not consume a sequence number.
- Event while full (default build): event is dropped, `overflow` sets, pointers and `count` are unchanged.
- `dump` is edge-detected with a registered copy. A rising `dump` sampled in CAPTURE moves the FSM to DRAIN.
  - An event accepted in that same cycle is stored before the transition.
- DRAIN:
  - Capture is frozen.
  - `out_valid = (count!=0)`; the out_* fields show the entry at the read pointer.
  - Pop on `out_valid && out_ready`: read pointer increments, `count` decrements.
  - When `count==0`, the FSM moves to DONE.
  - `out_ready` with `out_valid==0` has no effect.
- DONE:
  - `drain_done==1`, `out_valid==0`.
  - When `dump==0` is sampled, the FSM returns to CAPTURE. `overflow` clears at that transition; `seq_cnt` does not.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full is `count==DEPTH`; empty is `count==0`.
- Reset mid-operation (any state) abandons the drain. All reset values are taken on the next edge.

## Timing
- Reset values: `out_valid=0`, `out_seq=0`, `out_pc=0`, `out_rd=0`, `out_data=0`, `count=0`, `overflow=0`, `drain_done=0`, FSM=CAPTURE, `seq_cnt=0`, pointers=0, dump edge register=0.
- Event sampled at edge N: `count` reflects it after edge N.
- `dump` rising sampled at edge N: FSM is in DRAIN after edge N. `out_valid` is high in the cycle after N if `count>0`, i.e. 1-cycle latency.
- Empty buffer at a `dump` rise: DRAIN lasts exactly one cycle with `out_valid=0`, then DONE.
- out_* fields are a registered-array read of the head (show-ahead). The next entry is presented in the cycle after a pop.
- Throughput in DRAIN is one entry per cycle with `out_ready` held high.
- out_* field values are don't-care when `out_valid==0`. They must not be X after reset.
- `out_valid` never drops without a pop, except on reset.

## Configuration
- `WB_TRACE_OVERWRITE_EN`:
  - When defined, an event accepted while full overwrites the oldest entry. Read and write pointers both advance, `count` stays at DEPTH, and `overflow` sets.
  - When undefined, the new event is dropped (default behaviour above).

## Structure
- Package `wb_trace_pkg` holds:
  - `trace_entry_t` packed struct {seq[15:0], pc, rd[4:0], data}.
  - `trace_state_e` enum {CAPTURE, DRAIN, DONE}.
  - `SEQ_W=16`.
- Sub-module `wb_trace_fifo` holds storage, pointers, count and full/empty. It exposes push/pop/overwrite strobes. The top level contains the FSM, capture filter, dump edge detect and sequence counter.

## Test plan
- Reset, then writebacks (x1,0xDEADBEEF,pc 0x0), (x2,0x12345678,pc 0x4), (x7,0x4,pc 0x8); raise `dump`, `out_ready=1` → three beats in order with seq 0,1,2; then `drain_done=1`, `count=0`.
- Writeback to x0 with data 0x55 → `count` stays 0, no sequence number consumed; next x3 write gets seq 0.
- DEPTH+3 writebacks with seq-tagged data 0..18 in default build → `count=16`, `overflow=1`, drain yields data 0..15; with `WB_TRACE_OVERWRITE_EN` the drain yields 3..18.
- `out_ready` toggled 1/0 every cycle during drain → each entry appears exactly once; out_* are stable while `out_valid && !out_ready`.
- `dump` rises in the same cycle as a writeback of x5=0xFEDCBA98 → that entry is the last beat drained; a writeback during DRAIN is not captured.
- Reset asserted two beats into a 5-entry drain → next cycle `count=0`, `out_valid=0`, FSM in CAPTURE; a fresh capture starts at seq 0.
